// File: rtl/token_fifo.sv
// First-word-fall-through valid/ready token FIFO between a producer and the datapath.
// Optional high-water-mark output when TOKEN_FIFO_PEAK_EN is defined.
module token_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef TOKEN_FIFO_PEAK_EN
  ,
  output logic [$clog2(DEPTH):0]   peak
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop, flush;

  // Handshake flags decode registered occupancy only.
  assign in_ready  = (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != CW'(0));
  assign count     = cnt_q;
  assign out_data  = out_valid ? mem_q[rp_q] : WIDTH'(0);

  assign flush = reset | clear;
  assign push  = in_valid & in_ready;
  assign pop   = out_valid & out_ready;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (clear) begin
      wp_d  = AW'(0);
      rp_d  = AW'(0);
      cnt_d = CW'(0);
    end else begin
      if (push) wp_d = wp_q + AW'(1);
      if (pop)  rp_d = rp_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q  <= AW'(0);
      rp_q  <= AW'(0);
      cnt_q <= CW'(0);
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is intentionally not reset; flushed pointers make stale entries unreachable.
  always_ff @(posedge clock) begin
    if (push && !flush) mem_q[wp_q] <= in_data;
  end

`ifdef TOKEN_FIFO_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (clear)                peak_d = CW'(0);
    else if (cnt_d > peak_q)  peak_d = cnt_d;
  end

  always_ff @(posedge clock) begin
    if (reset) peak_q <= CW'(0);
    else       peak_q <= peak_d;
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_token_fifo.sv
// Scoreboard bench for token_fifo: stimulus enqueues expected tokens, a negedge monitor
// checks every popped head token; state checks run inline after each clock.
module tb_token_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset, clear;
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;
  logic [CW-1:0]    count;
`ifdef TOKEN_FIFO_PEAK_EN
  logic [CW-1:0]    peak;
`endif

  int tests_run = 0;
  int fails     = 0;
  logic [WIDTH-1:0] exp_q[$];

  token_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
`ifdef TOKEN_FIFO_PEAK_EN
    ,
    .peak     (peak)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_tok(input logic [WIDTH-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    exp_q.push_back(v);
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: a pop happens at the next posedge whenever head is valid and taken.
  always @(negedge clock) begin
    if (!reset && !clear && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h expected no token", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          fails++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h", out_data, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] wrap_vals [10];
    int idx;
    wrap_vals = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};

    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(negedge clock);

    // 1. reset held two cycles
    step(); step();
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
`ifdef TOKEN_FIFO_PEAK_EN
    chk("rst_peak", 32'(peak), 32'd0);
`endif

    // 2. fill, refuse fifth, drain in order
    push_tok(4'h1);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'h1);
    push_tok(4'h2); push_tok(4'h3); push_tok(4'h4);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 4'h5;
    step();
    in_valid = 1'b0;
    chk("refused_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    repeat (4) step();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_out_data", 32'(out_data), 32'd0);
    step();
    chk("empty_pop_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // 3. wrap-around: push 3 / pop 3 until 10 tokens
    idx = 0;
    while (idx < 10) begin
      int n;
      n = 0;
      while (n < 3 && idx < 10) begin
        push_tok(wrap_vals[idx]);
        idx++; n++;
      end
      out_ready = 1'b1;
      repeat (n) step();
      out_ready = 1'b0;
    end
    chk("wrap_count", 32'(count), 32'd0);
    chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // 4. simultaneous push+pop at count=2
    push_tok(4'h7); push_tok(4'h8);
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      exp_q.push_back(WIDTH'(k));
      step();
      chk("pp_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b0;
    chk("pp_drain_count", 32'(count), 32'd0);

    // 5. clear mid-stream with push and pop in the same cycle
    push_tok(4'hB); push_tok(4'hC); push_tok(4'hD);
    chk("pre_clr_count", 32'(count), 32'd3);
    clear = 1'b1; in_valid = 1'b1; in_data = 4'h9; out_ready = 1'b1;
    exp_q.delete();
    step();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    push_tok(4'hA);
    chk("post_clr_head", 32'(out_data), 32'hA);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_clr_count", 32'(count), 32'd0);

`ifdef TOKEN_FIFO_PEAK_EN
    // 6. high-water mark
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("peak_clr0", 32'(peak), 32'd0);
    push_tok(4'h1); push_tok(4'h2); push_tok(4'h3);
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    push_tok(4'h4);
    chk("peak_val", 32'(peak), 32'd3);
    clear = 1'b1;
    exp_q.delete();
    step();
    clear = 1'b0;
    chk("peak_clr", 32'(peak), 32'd0);
`endif

    chk("sb_empty_end", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
